draw_sprite: RTL
================

# draw_sprite

Draws one 16x16, 8-bit-per-pixel sprite into the 320x240 frame buffer. It sits directly downstream of the sprite movement stage, which hands it an image index and a linear top-left pixel address (y*320 + x) over a start/rdy handshake. The block reads the sprite image ROM, skips transparent and off-screen pixels, and writes the rest to the frame buffer.

## Interface
- TRANSPARENT, 8'h00, pixel value that is never written (colour key)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  draw request; sampled only while rdy=1
- image  in  8  sprite image index; latched on accept
- coordinates  in  17  linear top-left address y*320+x; latched on accept
- rdy  out  1  1 only in IDLE; request accepted when start=1 and rdy=1
- img_addr  out  16  image ROM address {image, row[3:0], col[3:0]}
- img_data  in  8  ROM read data; valid exactly 1 cycle after img_addr
- fb_we  out  1  frame-buffer write strobe, one pixel per cycle
- fb_addr  out  17  frame-buffer pixel address
- fb_data  out  8  pixel value
- Clock is clk and reset is rst_n; reset is asynchronous and active-low.

## Operation
- States: IDLE, DIV, DRAW, FLUSH.
- IDLE: rdy=1. If start=1, latch image and coordinates, set off_screen = (coordinates >= 76800), and go to DIV. start is ignored in every other state; no queueing.
- DIV: 8 cycles of restoring division of the coordinates by 320.
  - Step i = 7..0: if rem >= 320<<i, subtract it and set q[i].
  - Result: y0 = q (8 bits), x0 = rem (9 bits, 0..319).
  - When off_screen=1 the quotient is don't-care and every pixel is clipped.
- DRAW: 256 cycles, row 0..15 outer loop, col 0..15 inner loop. Each cycle issues img_addr for (row, col).
  - Pixel address is computed incrementally: row_base starts at the latched coordinates and adds 320 per row. fb_addr = row_base + col; no multiplier.
  - A pipeline stage carries a valid flag, fb_addr and the clip flag forward one cycle to meet img_data.
  - Clip when off_screen, or x0+col >= 320, or y0+row >= 240. Widths are 10 bits for the x sum and 9 bits for the y sum, so no wrap.
  - Write when the stage is valid, not clipped, and img_data != TRANSPARENT. Then fb_we=1, fb_addr is the staged address, and fb_data=img_data.
- FLUSH: 1 cycle that completes the write for pixel (15,15), then IDLE.
- Outputs when nothing is written: fb_we=0, fb_addr=0, fb_data=0. img_addr is held at its last value in IDLE.

## Timing
- Reset values: state=IDLE, rdy=1, fb_we=0, fb_addr=0, fb_data=0, img_addr=0, and all internal registers 0.
- Accept cycle is T. The block is in DIV for T+1..T+8 and in DRAW for T+9..T+264. In DRAW, pixel k = row*16+col has its address issued at T+9+k and is written at T+10+k.
- FLUSH is at T+265. rdy returns to 1 at T+266. Duration is fixed at 266 cycles whatever the clipping or transparency.
- rdy falls in the cycle after accept. An upstream that waits for rdy to fall and then rise again sees exactly one completed draw.
- Back-to-back draws: start held high in cycle T+266 is accepted immediately.
- Reset mid-draw: the async clear forces fb_we=0 at once. No partial pixel is written after rst_n falls, and the block returns to IDLE.
- At most one write per cycle. Writes are strictly in increasing pixel order.

## Test plan
- image=3, coordinates=0, ROM filled with nonzero values. Required: 256 writes. The first write is at T+10 to addr 0 with ROM[0x0300]. The last is at T+265 to addr 15*320+15=4815. rdy=1 at T+266.
- coordinates=310 (x0=310, y0=0). Required: only col 0..9 written per row, i.e. 160 writes. No write to any address whose x >= 320 (no wrap onto the next line).
- coordinates=230*320+5. Required: rows 0..9 written, rows 10..15 suppressed, 160 writes total. Duration is still 266 cycles.
- ROM for image 7 has a checkerboard of 8'h00 and 8'h55. Required: 128 writes, all with fb_data=8'h55. The 8'h00 pixels are skipped.
- coordinates=76800. Required: zero fb_we pulses and rdy back at T+266. A start pulse at T+100 is ignored.
- rst_n low at T+50 during DRAW. Required: fb_we=0 immediately and rdy=1 after release. A new start then draws a full sprite correctly.

Source files
------------

// File: rtl/draw_sprite.sv
`default_nettype none
// ============================================================================
// Module   : draw_sprite
// Brief    : Draws one 16x16 8bpp sprite into a 320x240 frame buffer.
//            Reads the sprite ROM row by row, clips off-screen pixels and
//            skips the transparent colour key. Fixed 266-cycle duration.
// Revision : 1.0 - initial release
// ============================================================================
module draw_sprite #(
   parameter logic [7:0] TRANSPARENT = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  image,
   input  logic [16:0] coordinates,
   output logic        rdy,
   output logic [15:0] img_addr,
   input  logic [7:0]  img_data,
   output logic        fb_we,
   output logic [16:0] fb_addr,
   output logic [7:0]  fb_data
);

   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_DIV   = 2'd1;
   localparam logic [1:0]  S_DRAW  = 2'd2;
   localparam logic [1:0]  S_FLUSH = 2'd3;

   localparam logic [16:0] LINE_PIXELS   = 17'd320;
   localparam logic [16:0] SCREEN_PIXELS = 17'd76800;
   localparam logic [9:0]  SCREEN_W      = 10'd320;
   localparam logic [8:0]  SCREEN_H      = 9'd240;

   logic [1:0]  state;
   logic [7:0]  image_q;
   logic        off_screen;
   logic [16:0] rem;          // division remainder; holds x0 once DIV ends
   logic [7:0]  quo;          // division quotient; holds y0 once DIV ends
   logic [2:0]  div_step;
   logic [7:0]  pix;          // {row, col} of the address currently issued
   logic [16:0] row_base;     // frame-buffer address of (row, col=0)

   // Pipeline stage aligning the pixel address with the ROM read data
   logic        stg_valid;
   logic        stg_clip;
   logic [16:0] stg_addr;

   logic [16:0] div_sub;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [9:0]  x_sum;
   logic [8:0]  y_sum;
   logic        pix_clip;
   logic [16:0] pix_addr;

   assign div_sub  = LINE_PIXELS << div_step;
   assign row      = pix[7:4];
   assign col      = pix[3:0];
   // Sums are one bit wider than the screen limits so they never wrap
   assign x_sum    = {1'b0, rem[8:0]} + {6'd0, col};
   assign y_sum    = {1'b0, quo} + {5'd0, row};
   assign pix_clip = off_screen || (x_sum >= SCREEN_W) || (y_sum >= SCREEN_H);
   assign pix_addr = row_base + {13'd0, col};

   assign rdy      = (state == S_IDLE);

   // Write strobe is combinational from the stage so reset drops it at once
   always_comb begin
      fb_we   = 1'b0;
      fb_addr = 17'd0;
      fb_data = 8'd0;
      if (stg_valid && !stg_clip && (img_data != TRANSPARENT)) begin
         fb_we   = 1'b1;
         fb_addr = stg_addr;
         fb_data = img_data;
      end
   end

   // Control FSM: accept, divide coordinates by 320, scan 256 pixels, flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         image_q    <= 8'd0;
         off_screen <= 1'b0;
         rem        <= 17'd0;
         quo        <= 8'd0;
         div_step   <= 3'd0;
         pix        <= 8'd0;
         row_base   <= 17'd0;
         img_addr   <= 16'd0;
         stg_valid  <= 1'b0;
         stg_clip   <= 1'b0;
         stg_addr   <= 17'd0;
      end else begin
         case (state)
            S_IDLE: begin
               stg_valid <= 1'b0;
               if (start) begin
                  image_q    <= image;
                  rem        <= coordinates;
                  row_base   <= coordinates;
                  quo        <= 8'd0;
                  off_screen <= (coordinates >= SCREEN_PIXELS);
                  div_step   <= 3'd7;
                  state      <= S_DIV;
               end
            end
            S_DIV: begin
               // Restoring division, one quotient bit per cycle, MSB first
               if (rem >= div_sub) begin
                  rem           <= rem - div_sub;
                  quo[div_step] <= 1'b1;
               end
               if (div_step == 3'd0) begin
                  pix      <= 8'd0;
                  img_addr <= {image_q, 8'h00};
                  state    <= S_DRAW;
               end else begin
                  div_step <= div_step - 3'd1;
               end
            end
            S_DRAW: begin
               stg_valid <= 1'b1;
               stg_clip  <= pix_clip;
               stg_addr  <= pix_addr;
               if (col == 4'd15) begin
                  row_base <= row_base + LINE_PIXELS;
               end
               if (pix == 8'hFF) begin
                  state <= S_FLUSH;
               end else begin
                  pix      <= pix + 8'd1;
                  img_addr <= {image_q, pix + 8'd1};
               end
            end
            default: begin
               // FLUSH: the stage holds the last pixel for exactly this cycle
               stg_valid <= 1'b0;
               stg_clip  <= 1'b0;
               stg_addr  <= 17'd0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
